tx_rd_req_trigger: RTL and testbench
====================================

Name: tx_rd_req_trigger

Overview:
- TX-direction counterpart of the RX TLP trigger logic. The RX side pushes NIC data to host huge pages; this block pulls host-written packet data out of the current 2 MB host huge page.
- Tracks how many qwords the host has committed to the page, and how much internal TX buffer space is free.
- Issues memory-read request commands, one request/ack pair each, to the TLP read-request builder.
- On page exhaustion, hands the page back to the host-page manager.

Parameters:
- BUF_AW, 10: log2 of the internal TX buffer depth in qwords (1024 qwords = 8 KB).
- MAX_RD_QWORDS, 64: maximum qwords per read request (512 B MRRS). Must be a power of 2, ≤ 512.
- TIMEOUT_W, 16: width of the idle timer. A partial request is allowed after 2^TIMEOUT_W idle cycles.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: asynchronous active-low reset.
- huge_page_ready, in, 1: the current host huge page is armed. Level signal, held by the page manager.
- host_committed_qwords, in, 19: qwords written by the host into the current page. Monotonic within a page, range 0..2^18.
- read_req, out, 1: read-request command valid.
- read_req_ack, in, 1: builder accepted the command.
- read_req_offset, out, 18: qword offset within the page (byte address = offset<<3).
- read_req_qwords, out, 10: qwords to read, 1..MAX_RD_QWORDS.
- credit_return_valid, in, 1: the TX buffer drained qwords this cycle.
- credit_return_qwords, in, BUF_AW+1: number of qwords drained.
- huge_page_release, out, 1: current page fully consumed.
- huge_page_release_ack, in, 1: page manager took the page back.

Behaviour:
- Reset values (async on reset_n low): read_req=0, read_req_offset=0, read_req_qwords=0, huge_page_release=0.
  - Internal: rd_offset=0, credits=2^BUF_AW, timer=0, state=IDLE.
- Reset mid-operation aborts any outstanding request or release with no further outputs. The downstream builder is reset by the same reset_n.
- Credits:
  - credits += credit_return_qwords when credit_return_valid, every cycle in any state.
  - credits -= read_req_qwords in the UPDATE state.
  - Both are applied in the same cycle when coincident.
  - The result is clamped at 2^BUF_AW.
- avail is registered every cycle: avail = host_committed_qwords - rd_offset, 19-bit unsigned. If host_committed_qwords < rd_offset (a protocol error), treat avail as 0.
- chunk = min(MAX_RD_QWORDS, avail, credits, 512 - rd_offset[8:0]). Requests never cross a 4 KB boundary.
- State machine (one-hot):
  - IDLE:
    - If !huge_page_ready: stay, timer=0.
    - Else if rd_offset == 2^18 (page exhausted): go to RELEASE.
    - Else if chunk == MAX_RD_QWORDS, or chunk == 512 - rd_offset[8:0] with chunk > 0: go to CALC.
    - Else if chunk > 0 and timer all-ones: go to CALC (timeout flush).
    - timer increments in IDLE while chunk > 0 and no transition is taken. It clears otherwise, and on leaving IDLE.
  - CALC: latch read_req_qwords=chunk, read_req_offset=rd_offset[17:0], assert read_req. Go to REQ.
  - REQ: hold read_req and both payload outputs stable until read_req_ack.
    - On ack: read_req=0, go to UPDATE.
    - An ack in the same cycle as read_req's first assertion is not possible: read_req rises at CALC exit.
  - UPDATE: rd_offset += read_req_qwords (19-bit, may reach exactly 2^18); credits -= read_req_qwords. Go to IDLE.
  - RELEASE: assert huge_page_release and hold it until huge_page_release_ack. On ack: release=0, rd_offset=0, go to WAIT_PAGE.
  - WAIT_PAGE: wait one cycle, so the page manager can drop huge_page_ready or update host_committed_qwords. Go to IDLE.
- Latency: the first read_req is 3 cycles after a qualifying host_committed_qwords change (avail register, IDLE decision, CALC).
- One request is outstanding at a time. Completion tracking is not this block's job; credits model buffer space only.
- A request never exceeds credits at issue time, so buffer overflow cannot occur.

Test Plan:
- Full chunk: after reset, page ready, host_committed_qwords=200. Expect read_reqs (0,64), (64,64), (128,64). Then 8 qwords remain and stall until the timeout (2^16 idle cycles), then (192,8).
- 4 KB boundary: rd_offset=480 (after 7×64 + a 32-qword timeout flush), host=1000. Expect (480,32), then (512,64).
- Credit stall: BUF_AW=7 (128 credits), host=1024, no returns. Expect (0,64), (64,64), then no request. Return 40 qwords; after the timeout expect (128,40).
- Simultaneous credit return and UPDATE: 64 returned in the same cycle UPDATE subtracts 64. Credits are unchanged and never exceed 2^BUF_AW.
- Page end: host=2^18 with credits returned continuously. The last request is (262080,64), then huge_page_release=1 held until ack, rd_offset resets to 0, and the next page starts with a request at offset 0.
- Reset mid-REQ: assert reset_n=0 while read_req=1 and unacked. All outputs drop to 0 and credits restore to 2^BUF_AW.

Source files
------------

// File: rtl/tx_rd_req_trigger.sv
// TX read-request trigger: pulls host-written packet data out of the current 2 MB huge page
// in MRRS/4 KB-bounded chunks, limited by TX buffer credits, and hands exhausted pages back.
module tx_rd_req_trigger #(
   parameter int unsigned BUF_AW        = 10,
   parameter int unsigned MAX_RD_QWORDS = 64,
   parameter int unsigned TIMEOUT_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              huge_page_ready,
   input  logic [18:0]       host_committed_qwords,
   output logic              read_req,
   input  logic              read_req_ack,
   output logic [17:0]       read_req_offset,
   output logic [9:0]        read_req_qwords,
   input  logic              credit_return_valid,
   input  logic [BUF_AW:0]   credit_return_qwords,
   output logic              huge_page_release,
   input  logic              huge_page_release_ack
);

   localparam int unsigned OFF_W = 19;
   localparam int unsigned CW    = BUF_AW + 1;
   localparam int unsigned QW    = 10;
   localparam logic [OFF_W-1:0] PAGE_QWORDS = OFF_W'(32'd1 << 18);
   localparam logic [OFF_W-1:0] MAX_Q       = OFF_W'(MAX_RD_QWORDS);
   localparam logic [CW-1:0]    CREDIT_MAX  = CW'(32'd1 << BUF_AW);

   typedef enum logic [5:0] {
      IDLE      = 6'b000001,
      CALC      = 6'b000010,
      REQ       = 6'b000100,
      UPDATE    = 6'b001000,
      RELEASE   = 6'b010000,
      WAIT_PAGE = 6'b100000
   } state_t;

   state_t               state, state_d;
   logic [OFF_W-1:0]     rd_offset, rd_offset_d;
   logic [OFF_W-1:0]     avail, avail_d;
   logic [CW-1:0]        credits, credits_d;
   logic [TIMEOUT_W-1:0] timer, timer_d;
   logic                 read_req_d, release_d;
   logic [17:0]          offset_d;
   logic [QW-1:0]        qwords_d;
   logic [QW-1:0]        room;
   logic [OFF_W-1:0]     chunk_w;
   logic [CW:0]          credit_sum;

   // Largest legal request: MRRS, committed data, buffer space, and distance to the next 4 KB line
   always_comb begin
      room    = 10'd512 - {1'b0, rd_offset[8:0]};
      chunk_w = MAX_Q;
      if (avail < chunk_w)            chunk_w = avail;
      if (OFF_W'(credits) < chunk_w)  chunk_w = OFF_W'(credits);
      if (OFF_W'(room) < chunk_w)     chunk_w = OFF_W'(room);
   end

   // Returns and UPDATE consumption combine in one cycle; an extra bit keeps the sum exact before clamping
   always_comb begin
      credit_sum = {1'b0, credits};
      if (credit_return_valid) credit_sum = credit_sum + {1'b0, credit_return_qwords};
      if (state == UPDATE)     credit_sum = credit_sum - (CW+1)'(read_req_qwords);
      credits_d = (credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : credit_sum[CW-1:0];
   end

   always_comb begin
      state_d     = state;
      rd_offset_d = rd_offset;
      timer_d     = '0;
      read_req_d  = read_req;
      offset_d    = read_req_offset;
      qwords_d    = read_req_qwords;
      release_d   = huge_page_release;
      case (state)
         IDLE: begin
            if (huge_page_ready) begin
               if (rd_offset == PAGE_QWORDS) begin
                  state_d   = RELEASE;
                  release_d = 1'b1;
               end else if (chunk_w == MAX_Q ||
                            (chunk_w == OFF_W'(room) && chunk_w != '0)) begin
                  state_d = CALC;
               end else if (chunk_w != '0 && timer == '1) begin
                  state_d = CALC;
               end else if (chunk_w != '0) begin
                  timer_d = timer + TIMEOUT_W'(1);
               end
            end
         end
         CALC: begin
            read_req_d = 1'b1;
            offset_d   = rd_offset[17:0];
            qwords_d   = QW'(chunk_w);
            state_d    = REQ;
         end
         REQ: begin
            if (read_req_ack) begin
               read_req_d = 1'b0;
               state_d    = UPDATE;
            end
         end
         UPDATE: begin
            rd_offset_d = rd_offset + OFF_W'(read_req_qwords);
            state_d     = IDLE;
         end
         RELEASE: begin
            if (huge_page_release_ack) begin
               release_d   = 1'b0;
               rd_offset_d = '0;
               state_d     = WAIT_PAGE;
            end
         end
         WAIT_PAGE: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      // Built from the next offset so IDLE never acts on a pre-UPDATE value
      avail_d = (host_committed_qwords >= rd_offset_d) ? host_committed_qwords - rd_offset_d : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         rd_offset         <= '0;
         avail             <= '0;
         credits           <= CREDIT_MAX;
         timer             <= '0;
         read_req          <= 1'b0;
         read_req_offset   <= '0;
         read_req_qwords   <= '0;
         huge_page_release <= 1'b0;
      end else begin
         state             <= state_d;
         rd_offset         <= rd_offset_d;
         avail             <= avail_d;
         credits           <= credits_d;
         timer             <= timer_d;
         read_req          <= read_req_d;
         read_req_offset   <= offset_d;
         read_req_qwords   <= qwords_d;
         huge_page_release <= release_d;
      end
   end

endmodule

// File: tb/tb_tx_rd_req_trigger.sv
// Directed bench for tx_rd_req_trigger: expected requests are queued as stimulus is applied
// and compared as the DUT issues them; a second instance covers the small-buffer case.
module tb_tx_rd_req_trigger;

   localparam int unsigned TW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, ready, ack, rel_ack, cr_v, sel;
   logic [18:0] host;
   int          cr_n;

   logic        req_a, rel_a, req_b, rel_b;
   logic [17:0] off_a, off_b;
   logic [9:0]  q_a, q_b;
   logic [10:0] crq_a;
   logic [7:0]  crq_b;
   logic        ack_a, ack_b, rel_ack_a, rel_ack_b;
   logic        req, rel;
   logic [17:0] off;
   logic [9:0]  q;

   assign crq_a     = 11'(cr_n);
   assign crq_b     = 8'(cr_n);
   assign ack_a     = ack & ~sel;
   assign ack_b     = ack & sel;
   assign rel_ack_a = rel_ack & ~sel;
   assign rel_ack_b = rel_ack & sel;
   assign req = sel ? req_b : req_a;
   assign rel = sel ? rel_b : rel_a;
   assign off = sel ? off_b : off_a;
   assign q   = sel ? q_b   : q_a;

   tx_rd_req_trigger #(.BUF_AW(10), .MAX_RD_QWORDS(64), .TIMEOUT_W(TW)) dut_a (
      .clk(clk), .reset_n(reset_n), .huge_page_ready(ready), .host_committed_qwords(host),
      .read_req(req_a), .read_req_ack(ack_a), .read_req_offset(off_a), .read_req_qwords(q_a),
      .credit_return_valid(cr_v), .credit_return_qwords(crq_a),
      .huge_page_release(rel_a), .huge_page_release_ack(rel_ack_a));

   tx_rd_req_trigger #(.BUF_AW(7), .MAX_RD_QWORDS(64), .TIMEOUT_W(TW)) dut_b (
      .clk(clk), .reset_n(reset_n), .huge_page_ready(ready), .host_committed_qwords(host),
      .read_req(req_b), .read_req_ack(ack_b), .read_req_offset(off_b), .read_req_qwords(q_b),
      .credit_return_valid(cr_v), .credit_return_qwords(crq_b),
      .huge_page_release(rel_b), .huge_page_release_ack(rel_ack_b));

   typedef struct packed { logic [17:0] off; logic [9:0] q; } req_t;
   req_t exp_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int o, input int n);
      req_t e;
      e.off = 18'(o);
      e.q   = 10'(n);
      exp_q.push_back(e);
   endtask

   // Wait (bounded) for the next request, compare with the scoreboard head, hold, then ack
   task automatic serve(input int budget, input int hold, input bit ret_upd, output int waited);
      int   n = 0;
      req_t e;
      while (req !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      chk("req_seen", 32'(req), 32'd1);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
         return;
      end
      e = exp_q.pop_front();
      if (req !== 1'b1) return;
      chk("req_offset", 32'(off), 32'(e.off));
      chk("req_qwords", 32'(q), 32'(e.q));
      repeat (hold) begin
         @(negedge clk);
         chk("hold_req", 32'(req), 32'd1);
         chk("hold_offset", 32'(off), 32'(e.off));
         chk("hold_qwords", 32'(q), 32'(e.q));
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("req_drop", 32'(req), 32'd0);
      if (ret_upd) begin
         cr_v = 1'b1;
         cr_n = 64;
         @(negedge clk);
         cr_v = 1'b0;
         cr_n = 0;
      end
   endtask

   task automatic do_reset();
      ack = 1'b0; rel_ack = 1'b0; cr_v = 1'b0; cr_n = 0;
      host = '0; ready = 1'b0; reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ready   = 1'b1;
      @(negedge clk);
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n;
      int seen;
      sel = 1'b0;
      do_reset();

      // reset state
      chk("rst_req", 32'(req_a), 32'd0);
      chk("rst_offset", 32'(off_a), 32'd0);
      chk("rst_qwords", 32'(q_a), 32'd0);
      chk("rst_release", 32'(rel_a), 32'd0);
      chk("rst_credits_a", 32'(dut_a.credits), 32'd1024);
      chk("rst_credits_b", 32'(dut_b.credits), 32'd128);

      // full chunks, then an 8-qword tail flushed by the idle timer
      host = 19'd200;
      push(0, 64); push(64, 64); push(128, 64);
      serve(10, 0, 1'b0, w);
      chk("first_latency", 32'(w), 32'd3);
      serve(10, 1, 1'b0, w);
      serve(10, 2, 1'b0, w);
      push(192, 8);
      serve(400, 0, 1'b0, w);
      chk("timeout_latency", 32'(w), 32'd258);
      @(negedge clk);
      chk("credits_after_200", 32'(dut_a.credits), 32'd824);

      // 4 KB boundary
      do_reset();
      host = 19'd480;
      for (int i = 0; i < 7; i++) push(i * 64, 64);
      push(448, 32);
      for (int i = 0; i < 7; i++) serve(10, 0, 1'b0, w);
      serve(400, 0, 1'b0, w);
      host = 19'd1000;
      push(480, 32); push(512, 64);
      serve(10, 0, 1'b0, w);
      chk("boundary_latency", 32'(w), 32'd3);
      serve(10, 0, 1'b0, w);
      chk("post_boundary_latency", 32'(w), 32'd3);

      // credit stall on the 128-qword buffer
      sel = 1'b1;
      do_reset();
      host = 19'd1024;
      push(0, 64); push(64, 64);
      serve(10, 0, 1'b0, w);
      serve(10, 0, 1'b0, w);
      seen = 0;
      repeat (400) begin
         @(negedge clk);
         if (req === 1'b1) seen++;
      end
      chk("credit_stall_no_req", 32'(seen), 32'd0);
      chk("credit_stall_zero", 32'(dut_b.credits), 32'd0);
      cr_v = 1'b1; cr_n = 40;
      @(negedge clk);
      cr_v = 1'b0; cr_n = 0;
      push(128, 40);
      serve(400, 0, 1'b0, w);
      @(negedge clk);
      chk("credit_after_40", 32'(dut_b.credits), 32'd0);
      sel = 1'b0;

      // credit return coincident with UPDATE, and clamping
      do_reset();
      host = 19'd64;
      push(0, 64);
      serve(10, 0, 1'b1, w);
      chk("credits_coincident_full", 32'(dut_a.credits), 32'd1024);
      host = 19'd128;
      push(64, 64);
      serve(10, 0, 1'b0, w);
      @(negedge clk);
      chk("credits_after_consume", 32'(dut_a.credits), 32'd960);
      host = 19'd192;
      push(128, 64);
      serve(10, 0, 1'b1, w);
      chk("credits_coincident", 32'(dut_a.credits), 32'd960);
      cr_v = 1'b1; cr_n = 200;
      @(negedge clk);
      cr_v = 1'b0; cr_n = 0;
      chk("credits_clamp", 32'(dut_a.credits), 32'd1024);

      // whole page, release handshake, next page
      do_reset();
      cr_v = 1'b1; cr_n = 64;
      host = 19'h40000;
      for (int i = 0; i < 4096; i++) push(i * 64, 64);
      for (int i = 0; i < 4096; i++) serve(10, 0, 1'b0, w);
      n = 0;
      while (rel !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("release_rise", 32'(rel), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("release_hold", 32'(rel), 32'd1);
         chk("no_req_in_release", 32'(req), 32'd0);
      end
      rel_ack = 1'b1;
      host    = 19'd64;
      @(negedge clk);
      rel_ack = 1'b0;
      chk("release_drop", 32'(rel), 32'd0);
      chk("rd_offset_reset", 32'(dut_a.rd_offset), 32'd0);
      push(0, 64);
      serve(10, 0, 1'b0, w);
      chk("next_page_latency", 32'(w), 32'd3);
      cr_v = 1'b0; cr_n = 0;

      // reset while a request is outstanding
      do_reset();
      host = 19'd128;
      push(0, 64);
      serve(10, 0, 1'b0, w);
      n = 0;
      while (req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("req_before_reset", 32'(req), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("reset_req", 32'(req_a), 32'd0);
      chk("reset_offset", 32'(off_a), 32'd0);
      chk("reset_qwords", 32'(q_a), 32'd0);
      chk("reset_release", 32'(rel_a), 32'd0);
      chk("reset_credits", 32'(dut_a.credits), 32'd1024);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
